// File: rtl/i_tree_param.sv
// Isolation-tree anomaly scorer: deserialises MSB-first samples, walks a heap-ordered threshold tree one level/cycle.
// Result 1+path_len cycles after the last bit; result held until score_ready, one-deep buffer, later samples dropped (sticky overrun).
module i_tree_param #(
    parameter int                                DATA_W   = 8,
    parameter int                                DEPTH    = 3,
    parameter logic [(2**DEPTH-1)*DATA_W-1:0]    THRESH   = 56'hE0A06020C04080,
    parameter logic [2**DEPTH-2:0]               ISO_MASK = 7'b0000100,
    parameter int                                ANOM_LEN = 2,
    parameter int                                CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sensor_data,
    input  logic                         sensor_valid,
    input  logic                         frame_sync,
    input  logic                         score_ready,
    output logic                         score_valid,
    output logic                         anomaly_detected,
    output logic [$clog2(DEPTH+1)-1:0]   path_len,
    output logic [DATA_W-1:0]            sample_out,
    output logic                         overrun,
    output logic [CNT_W-1:0]             anomaly_count
);
    localparam int PL_W  = $clog2(DEPTH+1);
    localparam int NW    = DEPTH + 1;
    localparam int CW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int NODES = 2**DEPTH - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Tables padded to the full child-index range so lookups need no range guard.
    logic [DATA_W-1:0] thr [2**NW];
    logic [2**NW-1:0]  iso_ext;

    for (genvar i = 0; i < 2**NW; i++) begin : g_tab
        if (i < NODES) begin : g_node
            assign thr[i] = THRESH[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign thr[i] = '0;
        end
        if (i > 0 && i < NODES) begin : g_iso
            assign iso_ext[i] = ISO_MASK[i];
        end else begin : g_noiso
            assign iso_ext[i] = 1'b0;
        end
    end

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] samp_q, samp_d;
    logic [NW-1:0]     node_q, node_d;
    logic [PL_W-1:0]   level_q, level_d;
    logic              score_valid_q, score_valid_d;
    logic              anom_q, anom_d;
    logic [PL_W-1:0]   path_q, path_d;
    logic [DATA_W-1:0] sample_out_q, sample_out_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  acnt_q, acnt_d;

    logic [CW-1:0]     eff_cnt;
    logic              complete;
    logic              pop;
    logic [DATA_W-1:0] full;
    logic              lt;
    logic [NW-1:0]     child;
    logic [PL_W-1:0]   lvl_nx;
    logic              finish;
    logic [PL_W-1:0]   fin_len;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        hold_v_d      = hold_v_q;
        samp_d        = samp_q;
        node_d        = node_q;
        level_d       = level_q;
        score_valid_d = score_valid_q;
        anom_d        = anom_q;
        path_d        = path_q;
        sample_out_d  = sample_out_q;
        overrun_d     = overrun_q;
        acnt_d        = acnt_q;
        finish        = 1'b0;
        fin_len       = '0;

        eff_cnt  = frame_sync ? '0 : cnt_q;
        complete = sensor_valid && (eff_cnt == CW'(DATA_W-1));
        pop      = (state_q == S_IDLE) && hold_v_q;
        full     = (shift_q << 1) | DATA_W'(sensor_data);

        cnt_d = eff_cnt;
        if (sensor_valid) begin
            shift_d = full;
            cnt_d   = complete ? '0 : eff_cnt + CW'(1);
        end

        // A pop and a completing write on the same edge both take effect.
        if (pop) hold_v_d = 1'b0;
        if (complete) begin
            if (hold_v_q && !pop) begin
                overrun_d = 1'b1;
            end else begin
                hold_d   = full;
                hold_v_d = 1'b1;
            end
        end

        lt     = samp_q < thr[node_q];
        child  = (node_q << 1) + (lt ? NW'(1) : NW'(2));
        lvl_nx = level_q + PL_W'(1);

        case (state_q)
            S_IDLE: begin
                if (hold_v_q) begin
                    samp_d  = hold_q;
                    node_d  = '0;
                    level_d = '0;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (lvl_nx == PL_W'(DEPTH)) begin
                    finish  = 1'b1;
                    fin_len = PL_W'(DEPTH);
                end else if (iso_ext[child]) begin
                    finish  = 1'b1;
                    fin_len = lvl_nx;
                end else begin
                    node_d  = child;
                    level_d = lvl_nx;
                end
                if (finish) begin
                    state_d       = S_DONE;
                    score_valid_d = 1'b1;
                    path_d        = fin_len;
                    sample_out_d  = samp_q;
                    anom_d        = int'(fin_len) < ANOM_LEN;
                end
            end
            S_DONE: begin
                if (score_ready) begin
                    score_valid_d = 1'b0;
                    state_d       = S_IDLE;
                    if (anom_q && (acnt_q != '1)) acnt_d = acnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            hold_q        <= '0;
            hold_v_q      <= 1'b0;
            samp_q        <= '0;
            node_q        <= '0;
            level_q       <= '0;
            score_valid_q <= 1'b0;
            anom_q        <= 1'b0;
            path_q        <= '0;
            sample_out_q  <= '0;
            overrun_q     <= 1'b0;
            acnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_v_q      <= hold_v_d;
            samp_q        <= samp_d;
            node_q        <= node_d;
            level_q       <= level_d;
            score_valid_q <= score_valid_d;
            anom_q        <= anom_d;
            path_q        <= path_d;
            sample_out_q  <= sample_out_d;
            overrun_q     <= overrun_d;
            acnt_q        <= acnt_d;
        end
    end

    assign score_valid      = score_valid_q;
    assign anomaly_detected = anom_q;
    assign path_len         = path_q;
    assign sample_out       = sample_out_q;
    assign overrun          = overrun_q;
    assign anomaly_count    = acnt_q;

endmodule
